switch_matrix_cfg: RTL and testbench

- Parametrised programmable switch box for the FPGA routing fabric, with four bidirectional pin sides: top, right, bottom and left.
- Each pin holds one routing entry that either drives the pin from any pin on any side, or leaves it hi-Z.
- Entries are loaded at run time through a serial configuration shift chain with a start/busy/done handshake, replacing fixed power-up contents.
- A shadow/active double buffer ensures routing only changes on a single-cycle commit, never while bits are still shifting.

---
 rtl/switch_matrix_pkg.sv | 27 ++
 rtl/switch_matrix_pin_mux.sv | 54 +++++
 rtl/switch_matrix_cfg.sv | 138 +++++++++++++
 tb/tb_switch_matrix_cfg.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_matrix_pkg.sv
// switch_matrix_pkg: shared definitions for the switch_matrix_cfg routing box.
//   - SIDE_* : 3-bit source-side codes used in each routing entry
//   - ST_*   : configuration FSM state encoding
//   - ent_width / chain_len : derived entry width and shift-chain length
package switch_matrix_pkg;

    localparam logic [2:0] SIDE_OFF    = 3'd0;
    localparam logic [2:0] SIDE_TOP    = 3'd1;
    localparam logic [2:0] SIDE_RIGHT  = 3'd2;
    localparam logic [2:0] SIDE_BOTTOM = 3'd3;
    localparam logic [2:0] SIDE_LEFT   = 3'd4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    function automatic int unsigned ent_width(input int unsigned idx_w);
        return 3 + idx_w;
    endfunction

    function automatic int unsigned chain_len(input int unsigned ntb,
                                              input int unsigned nlr,
                                              input int unsigned idx_w);
        return (2 * ntb + 2 * nlr) * ent_width(idx_w);
    endfunction

endpackage

// File: rtl/switch_matrix_pin_mux.sv
// switch_matrix_pin_mux: decodes one routing entry into a drive value and an
// output enable for a single pin.
//   entry  : {index, side} routing entry for this pin
//   top/right/bottom/left : current values of all four pin buses
//   drive  : value to place on the pin when enabled
//   enable : 1 = pin driven, 0 = pin left hi-Z
// The pin is released when the side code is off, the index is beyond the
// source side's width, or the entry names this very pin.
module switch_matrix_pin_mux
    import switch_matrix_pkg::*;
#(
    parameter int         NTB       = 5,
    parameter int         NLR       = 4,
    parameter int         IDX_W     = 3,
    parameter logic [2:0] SELF_SIDE = SIDE_OFF,
    parameter int         SELF_IDX  = 0
) (
    input  logic [IDX_W+2:0] entry,
    input  logic [NTB-1:0]   top,
    input  logic [NLR-1:0]   right,
    input  logic [NTB-1:0]   bottom,
    input  logic [NLR-1:0]   left,
    output logic             drive,
    output logic             enable
);

    localparam int SPAN = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] SELF_SEL = IDX_W'(SELF_IDX);

    logic [2:0]       side;
    logic [IDX_W-1:0] idx;
    logic [SPAN-1:0]  bus;
    int unsigned      width;

    assign side = entry[2:0];
    assign idx  = entry[IDX_W+2:3];

    // Buses are zero-padded to the full index span so any index is a legal
    // select; the width test below decides whether the pin is actually driven.
    always_comb begin
        bus   = '0;
        width = 0;
        case (side)
            SIDE_TOP:    begin bus[NTB-1:0] = top;    width = NTB; end
            SIDE_RIGHT:  begin bus[NLR-1:0] = right;  width = NLR; end
            SIDE_BOTTOM: begin bus[NTB-1:0] = bottom; width = NTB; end
            SIDE_LEFT:   begin bus[NLR-1:0] = left;   width = NLR; end
            default:     ;
        endcase
        drive  = bus[idx];
        enable = (32'(idx) < width) && !((side == SELF_SIDE) && (idx == SELF_SEL));
    end

endmodule

// File: rtl/switch_matrix_cfg.sv
// switch_matrix_cfg: programmable four-sided switch box with a serial
// configuration chain and shadow/active double buffering.
//   clk, rst            : fabric clock, asynchronous active-high reset
//   cfg_start           : pulse to begin a load (ignored while busy)
//   cfg_en, cfg_sin     : one serial bit shifted per cycle while cfg_en is high
//   cfg_abort           : abandon the load; active routing is kept
//   cfg_busy, cfg_done  : load in progress / one-cycle commit pulse
//   cfg_sout            : readback stream (0 unless readback is built in)
//   wtop, wright, wbottom, wleft : bidirectional pin sides
// Optional feature macro: SWITCH_MATRIX_CFG_READBACK_EN streams the live
// configuration out of cfg_sout while a new one shifts in.
module switch_matrix_cfg
    import switch_matrix_pkg::*;
#(
    parameter int NTB   = 5,
    parameter int NLR   = 4,
    parameter int IDX_W = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_start,
    input  logic           cfg_en,
    input  logic           cfg_sin,
    input  logic           cfg_abort,
    output logic           cfg_busy,
    output logic           cfg_done,
    output logic           cfg_sout,
    inout  wire  [NTB-1:0] wtop,
    inout  wire  [NLR-1:0] wright,
    inout  wire  [NTB-1:0] wbottom,
    inout  wire  [NLR-1:0] wleft
);

    localparam int ENT_W = ent_width(IDX_W);
    localparam int NENT  = 2 * NTB + 2 * NLR;
    localparam int CHAIN = chain_len(NTB, NLR, IDX_W);
    localparam int CNT_W = $clog2(CHAIN + 1);

    localparam int BASE_RIGHT  = NTB;
    localparam int BASE_BOTTOM = NTB + NLR;
    localparam int BASE_LEFT   = 2 * NTB + NLR;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CHAIN-1:0] shadow;
    logic [CHAIN-1:0] active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            shadow <= '0;
            active <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_start && !cfg_abort) begin
                        state <= ST_LOAD;
                        cnt   <= '0;
`ifdef SWITCH_MATRIX_CFG_READBACK_EN
                        shadow <= active;
`endif
                    end
                end
                ST_LOAD: begin
                    if (cfg_abort) begin
                        state <= ST_IDLE;
                    end else if (cfg_en) begin
                        shadow <= {shadow[CHAIN-2:0], cfg_sin};
                        cnt    <= cnt + 1'b1;
                        if (cnt == CNT_W'(CHAIN - 1)) begin
                            state <= ST_COMMIT;
                        end
                    end
                end
                ST_COMMIT: begin
                    if (!cfg_abort) begin
                        active <= shadow;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cfg_busy = (state == ST_LOAD) || (state == ST_COMMIT);
    assign cfg_done = (state == ST_COMMIT) && !cfg_abort;

`ifdef SWITCH_MATRIX_CFG_READBACK_EN
    assign cfg_sout = (state == ST_LOAD) ? shadow[CHAIN-1] : 1'b0;
`else
    assign cfg_sout = 1'b0;
`endif

    // One mux per entry; entry k lives at active[k*ENT_W +: ENT_W] in the
    // order top, right, bottom, left.
    for (genvar i = 0; i < NTB; i++) begin : g_top
        logic drive, enable;
        switch_matrix_pin_mux #(.NTB(NTB), .NLR(NLR), .IDX_W(IDX_W),
                                .SELF_SIDE(SIDE_TOP), .SELF_IDX(i)) u_mux (
            .entry(active[i*ENT_W +: ENT_W]),
            .top(wtop), .right(wright), .bottom(wbottom), .left(wleft),
            .drive(drive), .enable(enable));
        assign wtop[i] = enable ? drive : 1'bz;
    end

    for (genvar i = 0; i < NLR; i++) begin : g_right
        logic drive, enable;
        switch_matrix_pin_mux #(.NTB(NTB), .NLR(NLR), .IDX_W(IDX_W),
                                .SELF_SIDE(SIDE_RIGHT), .SELF_IDX(i)) u_mux (
            .entry(active[(BASE_RIGHT+i)*ENT_W +: ENT_W]),
            .top(wtop), .right(wright), .bottom(wbottom), .left(wleft),
            .drive(drive), .enable(enable));
        assign wright[i] = enable ? drive : 1'bz;
    end

    for (genvar i = 0; i < NTB; i++) begin : g_bottom
        logic drive, enable;
        switch_matrix_pin_mux #(.NTB(NTB), .NLR(NLR), .IDX_W(IDX_W),
                                .SELF_SIDE(SIDE_BOTTOM), .SELF_IDX(i)) u_mux (
            .entry(active[(BASE_BOTTOM+i)*ENT_W +: ENT_W]),
            .top(wtop), .right(wright), .bottom(wbottom), .left(wleft),
            .drive(drive), .enable(enable));
        assign wbottom[i] = enable ? drive : 1'bz;
    end

    for (genvar i = 0; i < NLR; i++) begin : g_left
        logic drive, enable;
        switch_matrix_pin_mux #(.NTB(NTB), .NLR(NLR), .IDX_W(IDX_W),
                                .SELF_SIDE(SIDE_LEFT), .SELF_IDX(i)) u_mux (
            .entry(active[(BASE_LEFT+i)*ENT_W +: ENT_W]),
            .top(wtop), .right(wright), .bottom(wbottom), .left(wleft),
            .drive(drive), .enable(enable));
        assign wleft[i] = enable ? drive : 1'bz;
    end

endmodule

// File: tb/tb_switch_matrix_cfg.sv
// tb_switch_matrix_cfg: directed scoreboard bench for switch_matrix_cfg.
// Stimulus queues expected observations; a negedge monitor compares them and
// matches each cfg_done pulse against the expected commit cycle.
module tb_switch_matrix_cfg;

    localparam int NTB   = 5;
    localparam int NLR   = 4;
    localparam int IDX_W = 3;
    localparam int ENT_W = 6;
    localparam int CHAIN = 108;

    localparam int S_TOP = 0, S_RIGHT = 1, S_BOTTOM = 2, S_LEFT = 3;
    localparam int S_BUSY = 4, S_DONE = 5, S_SOUT = 6;
    localparam int EZ = 2;  // expected value meaning hi-Z

    typedef struct {
        int    sel;
        int    idx;
        int    exp;
        string name;
    } chk_t;

    logic clk = 1'b0, rst = 1'b1;
    logic cfg_start = 1'b0, cfg_en = 1'b0, cfg_sin = 1'b0, cfg_abort = 1'b0;
    wire  cfg_busy, cfg_done, cfg_sout;
    wire  [NTB-1:0] wtop, wbottom;
    wire  [NLR-1:0] wright, wleft;

    logic [NTB-1:0] top_oe = '0, top_drv = '0, bottom_oe = '0, bottom_drv = '0;
    logic [NLR-1:0] right_oe = '0, right_drv = '0, left_oe = '0, left_drv = '0;
    logic [NTB-1:0] top_z, bottom_z, top_v, bottom_v;
    logic [NLR-1:0] right_z, left_z, right_v, left_v;

    for (genvar i = 0; i < NTB; i++) begin : g_tb_tb
        assign wtop[i]     = top_oe[i]    ? top_drv[i]    : 1'bz;
        assign wbottom[i]  = bottom_oe[i] ? bottom_drv[i] : 1'bz;
        assign top_z[i]    = (wtop[i] === 1'bz);
        assign bottom_z[i] = (wbottom[i] === 1'bz);
    end
    for (genvar i = 0; i < NLR; i++) begin : g_tb_lr
        assign wright[i]  = right_oe[i] ? right_drv[i] : 1'bz;
        assign wleft[i]   = left_oe[i]  ? left_drv[i]  : 1'bz;
        assign right_z[i] = (wright[i] === 1'bz);
        assign left_z[i]  = (wleft[i] === 1'bz);
    end
    assign top_v    = wtop;
    assign bottom_v = wbottom;
    assign right_v  = wright;
    assign left_v   = wleft;

    switch_matrix_cfg #(.NTB(NTB), .NLR(NLR), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_en(cfg_en), .cfg_sin(cfg_sin),
        .cfg_abort(cfg_abort), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
        .cfg_sout(cfg_sout),
        .wtop(wtop), .wright(wright), .wbottom(wbottom), .wleft(wleft));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    chk_t chk_q[$];
    int   done_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    logic [CHAIN-1:0] cur_active = '0;

    function automatic string fmt(input int v);
        return (v == EZ) ? "z" : $sformatf("%0d", v);
    endfunction

    function automatic void do_check(input chk_t c);
        logic az, av;
        int   act;
        az = 1'b0;
        av = 1'b0;
        case (c.sel)
            S_TOP:    begin az = top_z[c.idx];    av = top_v[c.idx];    end
            S_RIGHT:  begin az = right_z[c.idx];  av = right_v[c.idx];  end
            S_BOTTOM: begin az = bottom_z[c.idx]; av = bottom_v[c.idx]; end
            S_LEFT:   begin az = left_z[c.idx];   av = left_v[c.idx];   end
            S_BUSY:   av = cfg_busy;
            S_DONE:   av = cfg_done;
            default:  av = cfg_sout;
        endcase
        act = az ? EZ : int'(av);
        n_checks++;
        if (act == c.exp) n_pass++;
        else $display("FAIL %s[%0d]: got %s, required %s at cycle %0d",
                      c.name, c.idx, fmt(act), fmt(c.exp), cyc);
    endfunction

    always @(negedge clk) begin
        while (chk_q.size() > 0) do_check(chk_q.pop_front());
        if (cfg_done) begin
            n_checks++;
            if (done_q.size() == 0) begin
                $display("FAIL done_unexpected: cfg_done=1 at cycle %0d, required 0", cyc);
            end else begin
                int e;
                e = done_q.pop_front();
                if (e == cyc) n_pass++;
                else $display("FAIL done_cycle: pulse at cycle %0d, required cycle %0d", cyc, e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int sel, input int idx, input int exp, input string name);
        chk_t c;
        c.sel  = sel;
        c.idx  = idx;
        c.exp  = exp;
        c.name = name;
        chk_q.push_back(c);
    endtask

    function automatic logic [CHAIN-1:0] put(input logic [CHAIN-1:0] v, input int k,
                                             input int idx, input int side);
        v[k*ENT_W +: ENT_W] = {3'(idx), 3'(side)};
        return v;
    endfunction

    // Shifts v MSB-first. stall_at/abort_at/rst_at < 0 disable those events.
    task automatic load(input logic [CHAIN-1:0] v, input int stall_at, input int stall_len,
                        input int stall_top0, input int abort_at, input int rst_at);
        logic [CHAIN-1:0] old;
        int t_en;
        old = cur_active;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        t_en = cyc;
        if (abort_at < 0 && rst_at < 0)
            done_q.push_back(t_en + CHAIN + ((stall_at >= 0) ? stall_len : 0));
        for (int b = 0; b < CHAIN; b++) begin
            if (b == stall_at) begin
                cfg_en = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    chk(S_BUSY, 0, 1, "stall_busy");
                    if (s == stall_len / 2) chk(S_TOP, 0, stall_top0, "stall_pin_hold");
                    step();
                end
            end
            if (b == rst_at) begin
                rst = 1'b1;
                cfg_en = 1'b0;
                cur_active = '0;
                chk(S_TOP, 0, EZ, "midrst_pin");
                chk(S_BOTTOM, 2, EZ, "midrst_pin");
                chk(S_RIGHT, 0, EZ, "midrst_pin");
                chk(S_BUSY, 0, 0, "midrst_busy");
                chk(S_SOUT, 0, 0, "midrst_sout");
                step();
                rst = 1'b0;
                step();
                return;
            end
            cfg_en  = 1'b1;
            cfg_sin = v[CHAIN-1-b];
            if (b == abort_at) begin
                cfg_abort = 1'b1;
                step();
                cfg_abort = 1'b0;
                cfg_en = 1'b0;
                chk(S_BUSY, 0, 0, "abort_busy");
                step();
                return;
            end
`ifdef SWITCH_MATRIX_CFG_READBACK_EN
            chk(S_SOUT, 0, int'(old[CHAIN-1-b]), "readback_bit");
`else
            chk(S_SOUT, 0, 0, "sout_tied");
`endif
            step();
        end
        cfg_en = 1'b0;
        step();
        cur_active = v;
    endtask

    logic [CHAIN-1:0] cfg_a, cfg_b;

    initial begin
        // Reset: every pin released, handshake outputs low.
        step();
        step();
        for (int i = 0; i < NTB; i++) begin
            chk(S_TOP, i, EZ, "reset_top");
            chk(S_BOTTOM, i, EZ, "reset_bottom");
        end
        for (int i = 0; i < NLR; i++) begin
            chk(S_RIGHT, i, EZ, "reset_right");
            chk(S_LEFT, i, EZ, "reset_left");
        end
        chk(S_BUSY, 0, 0, "reset_busy");
        chk(S_DONE, 0, 0, "reset_done");
        chk(S_SOUT, 0, 0, "reset_sout");
        step();
        rst = 1'b0;
        step();

        // top0 <- right2.
        cfg_a = put('0, 0, 2, 2);
        load(cfg_a, -1, 0, 0, -1, -1);
        right_oe[2]  = 1'b1;
        right_drv[2] = 1'b1;
        chk(S_TOP, 0, 1, "route_top0_hi");
        chk(S_TOP, 1, EZ, "unrouted_top1");
        chk(S_BUSY, 0, 0, "idle_busy");
        step();
        right_drv[2] = 1'b0;
        chk(S_TOP, 0, 0, "route_top0_lo");
        step();

        // Out-of-range, self-select, off code 5, plus two more live routes;
        // loaded with a 20-cycle cfg_en stall.
        right_drv[2] = 1'b1;
        right_oe[1] = 1'b1;  right_drv[1] = 1'b1;
        left_oe[3] = 1'b1;   left_drv[3] = 1'b1;
        bottom_oe[4] = 1'b1; bottom_drv[4] = 1'b0;
        cfg_b = put(cfg_a, 14, 5, 2);  // left0  <- right5 (out of range)
        cfg_b = put(cfg_b, 1, 1, 1);   // top1   <- top1   (self)
        cfg_b = put(cfg_b, 11, 3, 4);  // bottom2 <- left3
        cfg_b = put(cfg_b, 5, 4, 3);   // right0 <- bottom4
        cfg_b = put(cfg_b, 15, 0, 5);  // left1  side code 5 = off
        load(cfg_b, 40, 20, 1, -1, -1);
        chk(S_TOP, 0, 1, "b_top0");
        chk(S_LEFT, 0, EZ, "b_left0_range");
        chk(S_TOP, 1, EZ, "b_top1_self");
        chk(S_LEFT, 1, EZ, "b_left1_off");
        chk(S_BOTTOM, 2, 1, "b_bottom2_hi");
        chk(S_RIGHT, 0, 0, "b_right0_lo");
        step();
        left_drv[3] = 1'b0;
        bottom_drv[4] = 1'b1;
        chk(S_BOTTOM, 2, 0, "b_bottom2_lo");
        chk(S_RIGHT, 0, 1, "b_right0_hi");
        step();

        // Abort on the final bit: cfg_b stays active, no done pulse.
        load(cfg_a, -1, 0, 0, 107, -1);
        chk(S_BOTTOM, 2, 0, "abort_keep_bottom2");
        chk(S_RIGHT, 0, 1, "abort_keep_right0");
        chk(S_LEFT, 0, EZ, "abort_keep_left0");
        step();

        // Reset at bit 50, then a clean reload.
        load(cfg_a, -1, 0, 0, -1, 50);
        load(cfg_b, -1, 0, 0, -1, -1);
        chk(S_BOTTOM, 2, 0, "reload_bottom2");
        chk(S_RIGHT, 0, 1, "reload_right0");
        chk(S_TOP, 0, 1, "reload_top0");
        step();

        // Replace cfg_b with cfg_a; with readback the old stream is checked bitwise.
        load(cfg_a, -1, 0, 0, -1, -1);
        chk(S_TOP, 0, 1, "final_top0");
        chk(S_BOTTOM, 2, EZ, "final_bottom2");
        chk(S_RIGHT, 0, EZ, "final_right0");
        step();

        repeat (3) step();
        while (done_q.size() > 0) begin
            n_checks++;
            $display("FAIL done_missing: no pulse, required at cycle %0d", done_q.pop_front());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
